// File: rtl/serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx_pkg
// Description : Shared types and defaults for the two-requester serial
//               transmit path (state encoding, requester index, arbiter pick).
// Revision    : 1.0 - initial release
// ============================================================================
package serial_tx_pkg;

  // Default frame length and inter-frame idle gap
  localparam int unsigned c_width_default = 24;
  localparam int unsigned c_gap_default   = 2;

  // Controller states; the ST_ prefix keeps them clear of the GAP parameter
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Requester index: 0 or 1
  typedef logic req_idx_t;

  // Round-robin pick: a lone request wins outright, a tie goes to the
  // requester that was not served last.
  function automatic req_idx_t rr_pick(input logic r0, input logic r1,
                                       input req_idx_t last);
    req_idx_t pick;
    if (r0 && r1) begin
      pick = ~last;
    end else if (r0) begin
      pick = 1'b0;
    end else begin
      pick = 1'b1;
    end
    return pick;
  endfunction

endpackage : serial_tx_pkg
`default_nettype wire

// File: rtl/piso_shift.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift
// Description : Parallel-in serial-out shift register, MSB first. Load and
//               shift are synchronous; load takes priority over shift.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] r_sh;

  // Capture a new word or shift left filling with zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh <= '0;
    end else if (load) begin
      r_sh <= din;
    end else if (shift_en) begin
      r_sh <= {r_sh[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = r_sh[WIDTH-1];

endmodule : piso_shift
`default_nettype wire

// File: rtl/serial_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx_arb
// Description : Round-robin arbiter between two parallel-word requesters,
//               feeding an MSB-first serial shifter with frame strobe, done
//               pulse and a programmable idle gap between frames.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_arb
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = c_width_default,
  parameter int GAP   = c_gap_default
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] din0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din1,
  output logic             ack0,
  output logic             ack1,
  output logic             sd,
  output logic             sframe,
  output logic             done,
  output logic             busy
);

  // Counter widths; the gap counter keeps one bit even when GAP is zero
  localparam int c_cw = $clog2(WIDTH);
  localparam int c_gw = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [c_cw-1:0] c_bit_last    = c_cw'(WIDTH - 1);
  localparam logic [c_cw-1:0] c_bit_prelast = c_cw'(WIDTH - 2);
  localparam logic [c_gw-1:0] c_gap_last    = c_gw'((GAP > 0) ? (GAP - 1) : 0);

  state_t            r_state;
  req_idx_t          r_grant;
  req_idx_t          r_last;
  logic [c_cw-1:0]   r_bit_cnt;
  logic [c_gw-1:0]   r_gap_cnt;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_sframe;
  logic              r_done;
  logic              r_busy;

  req_idx_t          w_pick;
  logic              w_load;
  logic              w_shift;
  logic              w_msb;
  logic [WIDTH-1:0]  w_din;

  assign w_pick  = rr_pick(req0, req1, r_last);
  assign w_load  = (r_state == ST_LOAD);
  assign w_shift = (r_state == ST_SHIFT);
  assign w_din   = r_grant ? din1 : din0;

  piso_shift #(
    .WIDTH (WIDTH)
  ) u_piso_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .shift_en (w_shift),
    .din      (w_din),
    .msb      (w_msb)
  );

  // Arbitration, sequencing, counters and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_sframe  <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req0 || req1) begin
            r_grant <= w_pick;
            r_ack0  <= (w_pick == 1'b0);
            r_ack1  <= (w_pick == 1'b1);
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_last    <= r_grant;
          r_bit_cnt <= '0;
          r_sframe  <= 1'b1;
          r_done    <= 1'b0;
          r_state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // done is raised so that it coincides with the final bit cycle
          r_done <= (r_bit_cnt == c_bit_prelast);
          if (r_bit_cnt == c_bit_last) begin
            r_sframe <= 1'b0;
            r_done   <= 1'b0;
            if (GAP > 0) begin
              r_gap_cnt <= '0;
              r_state   <= ST_GAP;
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == c_gap_last) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack0   = r_ack0;
  assign ack1   = r_ack1;
  assign sframe = r_sframe;
  assign sd     = r_sframe & w_msb;
  assign done   = r_done;
  assign busy   = r_busy;

endmodule : serial_tx_arb
`default_nettype wire

// File: tb/tb_serial_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_tx_arb
// Description : Directed bench for serial_tx_arb with a default instance
//               (WIDTH 24, GAP 2) and a GAP 0 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  // Default instance signals
  logic        rst  = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [23:0] din0 = '0;
  logic [23:0] din1 = '0;
  logic ack0, ack1, sd, sframe, done, busy;

  // GAP = 0 instance signals
  logic        rst_b  = 1'b1;
  logic        req0_b = 1'b0;
  logic        req1_b = 1'b0;
  logic [23:0] din0_b = '0;
  logic [23:0] din1_b = '0;
  logic ack0_b, ack1_b, sd_b, sframe_b, done_b, busy_b;

  serial_tx_arb #(.WIDTH(24), .GAP(2)) dut (
    .clk(clk), .rst(rst), .req0(req0), .din0(din0), .req1(req1), .din1(din1),
    .ack0(ack0), .ack1(ack1), .sd(sd), .sframe(sframe), .done(done), .busy(busy)
  );

  serial_tx_arb #(.WIDTH(24), .GAP(0)) dut_b (
    .clk(clk), .rst(rst_b), .req0(req0_b), .din0(din0_b), .req1(req1_b), .din1(din1_b),
    .ack0(ack0_b), .ack1(ack1_b), .sd(sd_b), .sframe(sframe_b), .done(done_b), .busy(busy_b)
  );

  task automatic test_reset();
    rst = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack0, ack1, sd, sframe, done, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 000000", {ack0, ack1, sd, sframe, done, busy});
    end
    checks++;
    if ({ack0_b, ack1_b, sd_b, sframe_b, done_b, busy_b} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs_g0 got %b want 000000", {ack0_b, ack1_b, sd_b, sframe_b, done_b, busy_b});
    end
    rst = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sframe !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b sframe=%b want 0 0", busy, sframe);
    end
  endtask

  task automatic test_single();
    logic [23:0] w;
    w = 24'hA5C3F0;
    req0 = 1'b1; din0 = w;
    @(negedge clk);
    checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0 || busy !== 1'b1 || sframe !== 1'b0) begin
      errors++;
      $display("FAIL single_ack ack0=%b ack1=%b busy=%b sframe=%b want 1 0 1 0", ack0, ack1, busy, sframe);
    end
    req0 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      checks++;
      if (sframe !== 1'b1 || sd !== w[23-i] || done !== (i == 23) || ack0 !== 1'b0) begin
        errors++;
        $display("FAIL single_bit%0d sframe=%b sd=%b done=%b ack0=%b want 1 %b %b 0",
                 i, sframe, sd, done, ack0, w[23-i], (i == 23));
      end
    end
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      checks++;
      if (sframe !== 1'b0 || sd !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_gap%0d sframe=%b sd=%b done=%b busy=%b want 0 0 0 1", g, sframe, sd, done, busy);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_tiebreak();
    int prev_rise;
    logic g;
    logic [23:0] w;
    prev_rise = -1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    din0 = 24'hA5C3F0; din1 = 24'h3C96E1;
    req0 = 1'b1; req1 = 1'b1;
    for (int f = 0; f < 4; f++) begin
      g = f[0];
      w = g ? din1 : din0;
      @(negedge clk);
      checks++;
      if (ack0 !== ~g || ack1 !== g) begin
        errors++;
        $display("FAIL tie_grant%0d ack0=%b ack1=%b want %b %b", f, ack0, ack1, ~g, g);
      end
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        if (i == 0) begin
          if (prev_rise >= 0) begin
            checks++;
            if (cyc - prev_rise != 28) begin
              errors++;
              $display("FAIL tie_period%0d got %0d want 28", f, cyc - prev_rise);
            end
          end
          prev_rise = cyc;
        end
        checks++;
        if (sframe !== 1'b1 || sd !== w[23-i]) begin
          errors++;
          $display("FAIL tie_f%0d_bit%0d sframe=%b sd=%b want 1 %b", f, i, sframe, sd, w[23-i]);
        end
      end
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        checks++;
        if (sframe !== 1'b0 || sd !== 1'b0) begin
          errors++;
          $display("FAIL tie_gap f%0d sframe=%b sd=%b want 0 0", f, sframe, sd);
        end
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
        errors++;
        $display("FAIL tie_idle f%0d busy=%b ack0=%b ack1=%b want 0 0 0", f, busy, ack0, ack1);
      end
      if (f == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
  endtask

  task automatic test_gap0();
    int prev_rise;
    prev_rise = -1;
    req1_b = 1'b1; din1_b = 24'h000001;
    for (int f = 0; f < 2; f++) begin
      @(negedge clk);
      checks++;
      if (ack1_b !== 1'b1 || ack0_b !== 1'b0) begin
        errors++;
        $display("FAIL g0_ack f%0d ack1=%b ack0=%b want 1 0", f, ack1_b, ack0_b);
      end
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        if (i == 0) begin
          if (prev_rise >= 0) begin
            checks++;
            if (cyc - prev_rise != 26) begin
              errors++;
              $display("FAIL g0_period got %0d want 26", cyc - prev_rise);
            end
          end
          prev_rise = cyc;
        end
        checks++;
        if (sframe_b !== 1'b1 || sd_b !== (i == 23) || done_b !== (i == 23)) begin
          errors++;
          $display("FAIL g0_f%0d_bit%0d sframe=%b sd=%b done=%b want 1 %b %b",
                   f, i, sframe_b, sd_b, done_b, (i == 23), (i == 23));
        end
      end
      @(negedge clk);
      checks++;
      if (busy_b !== 1'b0 || sframe_b !== 1'b0 || sd_b !== 1'b0) begin
        errors++;
        $display("FAIL g0_idle f%0d busy=%b sframe=%b sd=%b want 0 0 0", f, busy_b, sframe_b, sd_b);
      end
      if (f == 1) req1_b = 1'b0;
    end
  endtask

  task automatic test_midreset();
    logic [23:0] w;
    req0 = 1'b1; din0 = 24'hFFFFFF;
    @(negedge clk);
    checks++;
    if (ack0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_ack0 got %b want 1", ack0);
    end
    req0 = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (sframe !== 1'b1 || sd !== 1'b1) begin
        errors++;
        $display("FAIL mid_bit%0d sframe=%b sd=%b want 1 1", i, sframe, sd);
      end
      if (i == 10) rst = 1'b1;
    end
    @(negedge clk);
    checks++;
    if ({ack0, ack1, sd, sframe, done, busy} !== 6'b0) begin
      errors++;
      $display("FAIL mid_truncate got %b want 000000", {ack0, ack1, sd, sframe, done, busy});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ack0 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_after done=%b ack0=%b busy=%b want 0 0 0", done, ack0, busy);
    end
    w = 24'h5A5A5A;
    req1 = 1'b1; din1 = w;
    @(negedge clk);
    checks++;
    if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart_ack ack1=%b ack0=%b want 1 0", ack1, ack0);
    end
    req1 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      checks++;
      if (sframe !== 1'b1 || sd !== w[23-i] || done !== (i == 23)) begin
        errors++;
        $display("FAIL mid_restart_bit%0d sframe=%b sd=%b done=%b want 1 %b %b",
                 i, sframe, sd, done, w[23-i], (i == 23));
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_late();
    logic [23:0] w;
    req0 = 1'b1; din0 = 24'hC0FFEE;
    @(negedge clk);
    checks++;
    if (ack0 !== 1'b1) begin
      errors++;
      $display("FAIL late_ack0 got %b want 1", ack0);
    end
    req0 = 1'b0;
    repeat (24) @(negedge clk);
    @(negedge clk);
    checks++;
    if (ack1 !== 1'b0 || busy !== 1'b1 || sframe !== 1'b0) begin
      errors++;
      $display("FAIL late_gap1 ack1=%b busy=%b sframe=%b want 0 1 0", ack1, busy, sframe);
    end
    w = 24'h123456;
    req1 = 1'b1; din1 = w;
    @(negedge clk);
    checks++;
    if (ack1 !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL late_gap2 ack1=%b busy=%b want 0 1", ack1, busy);
    end
    @(negedge clk);
    checks++;
    if (ack1 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL late_idle ack1=%b busy=%b want 0 0", ack1, busy);
    end
    @(negedge clk);
    checks++;
    if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
      errors++;
      $display("FAIL late_ack1 ack1=%b ack0=%b want 1 0", ack1, ack0);
    end
    req1 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      checks++;
      if (sframe !== 1'b1 || sd !== w[23-i]) begin
        errors++;
        $display("FAIL late_bit%0d sframe=%b sd=%b want 1 %b", i, sframe, sd, w[23-i]);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_tiebreak();
    test_gap0();
    test_midreset();
    test_late();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_tx_arb
`default_nettype wire

// File: doc/serial_tx_arb.md
# serial_tx_arb

Two-requester controller for the 24-bit serial output path. It arbitrates round-robin between two parallel-word sources and loads the granted word into its internal shift register. It then shifts the word out MSB-first on a single data line with a frame strobe, and enforces a programmable idle gap between frames. It sits between the parallel producers and the serial pin, and replaces direct `start`-driven loading of the shifter.

## Interface
- `WIDTH`, 24, bits per frame; must be ≥ 2.
- `GAP`, 2, idle cycles after each frame before the next arbitration; 0 is allowed.
- `clk` input 1: sole clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0` input 1: requester 0 has a word pending. Held high until `ack0`.
- `din0` input WIDTH: requester 0 word. Must be stable while `req0` is high.
- `req1` input 1: requester 1 has a word pending. Held high until `ack1`.
- `din1` input WIDTH: requester 1 word. Must be stable while `req1` is high.
- `ack0` output 1: one-cycle pulse; `din0` is captured at the end of this cycle.
- `ack1` output 1: one-cycle pulse; `din1` is captured at the end of this cycle.
- `sd` output 1: serial data, MSB first. Forced to 0 when `sframe` is low.
- `sframe` output 1: high exactly during the WIDTH bit cycles of a frame.
- `done` output 1: pulses high during the last bit cycle of a completed frame.
- `busy` output 1: high in every state except IDLE.

## Operation
- The state machine has four states: IDLE, LOAD, SHIFT, GAP.
- **IDLE**
  - Sampled at each edge.
  - If any request is high, set `grant` and go to LOAD.
  - Otherwise stay in IDLE.
- **Arbitration (round-robin on `last`)**
  - Only one request high: that requester is granted.
  - Both requests high: the requester ≠ `last` is granted.
  - `last` is updated at the end of LOAD.
- **LOAD** (1 cycle)
  - `ack[grant]` = 1.
  - At the end of the cycle, the shifter loads `din[grant]`, the bit counter is cleared, and the FSM goes to SHIFT.
- **SHIFT** (WIDTH cycles)
  - `sframe` = 1 and `sd` = shifter MSB.
  - At each edge the shifter shifts left, filling with 0, and the counter increments.
  - In the cycle where counter = WIDTH−1, `done` = 1.
  - At the end of that cycle, go to GAP if GAP > 0, otherwise to IDLE.
- **GAP** (GAP cycles)
  - `sframe` = 0 and `sd` = 0; the gap counter counts GAP cycles.
  - Then go to IDLE.
- **Requester behaviour after `ack`**
  - A requester may keep `req` high to queue its next word.
  - That word is arbitrated on the next IDLE visit.
- **Reset**
  - State = IDLE; `last` = 1, so `req0` wins the first tie.
  - Shifter and all counters are cleared.
  - All outputs are 0.
- **Reset mid-frame**
  - The frame is truncated on the next cycle.
  - No `done` pulse is produced.
  - An `ack` already given is not repeated.
  - The requester must re-request.
- **Request dropped illegally before `ack`**
  - If the drop occurs during LOAD, capture still happens.
  - This is a protocol violation; it is not the block's responsibility.
- **Width rules**
  - Bit counter is $clog2(WIDTH) bits wide and never wraps past WIDTH−1.
  - Gap counter is $clog2(GAP+1) bits wide; it is unused when GAP = 0.

## Timing
- `req` high at edge k while IDLE → LOAD in cycle k+1 (`ack` high).
- First bit (MSB) appears in cycle k+2; last bit (LSB) appears in cycle k+WIDTH+1 with `done`.
- Request-to-first-bit latency is 2 cycles.
- Back-to-back frame period is 1 + 1 + WIDTH + GAP cycles (28 with defaults).
- Serial data sequence: frame bit i (i = 0..WIDTH−1) = captured word[WIDTH−1−i].
- Outputs are derived only from registers; there is no combinational path from `req`/`din` to any output.
- `busy` is low only in IDLE, including the cycle in which the request is sampled.

## Structure
- Package `serial_tx_pkg` holds:
  - the state enum (IDLE, LOAD, SHIFT, GAP);
  - default WIDTH/GAP localparams;
  - the requester index type.
- Sub-module `piso_shift`:
  - parameter WIDTH;
  - ports `clk`, `rst`, `load`, `shift_en`, `din[WIDTH-1:0]`, `msb`;
  - load and shift are both synchronous; load has priority over shift.
- The top level contains the arbiter, FSM, bit counter, gap counter, and output gating.

## Test plan
- **Reset state:** after `rst`, all outputs are 0 and `busy` = 0.
  - `req0` = 1, `din0` = 24'hA5C3F0.
  - Required: `ack0` in cycle 2; `sframe` high for exactly 24 cycles.
  - Required: `sd` = 1,0,1,0,0,1,0,1,… ending in 0; `done` on bit 24.
- **Tie-break:** `req0` and `req1` both held high.
  - Required grants alternate 0,1,0,1.
  - Required: consecutive `sframe` rising edges are exactly 28 cycles apart; gap `sd` = 0.
- **GAP = 0:** with `req1` held, `din1` = 24'h000001.
  - Required: frame period is 26 cycles.
  - Required: `sd` is high only on the last bit of each frame.
- **Mid-frame reset:** `rst` asserted at bit 10 of a frame.
  - Required: outputs are 0 the next cycle, with no `done`.
  - Then `req1` → the frame restarts cleanly with `ack1` and all 24 bits.
- **Late request:** `req1` asserted during a `req0` frame's GAP.
  - Required: `req1` is not granted until IDLE.
  - Required: `ack1` occurs exactly 1 cycle after the GAP ends.
